// File: rtl/elixirchip_es1_spu_pkg.sv
// elixirchip_es1_spu_pkg: shared constants and lane pipeline record for the SPU operand selector
package elixirchip_es1_spu_pkg;
  localparam int LATENCY_MAX = 8;
  localparam int DATA_MAX = 64;
  // Data is sized to the widest supported lane; narrower lanes use the low bits.
  typedef struct packed {
    logic [DATA_MAX-1:0] data;
    logic                valid;
    logic                err;
  } lane_t;
endpackage

// File: rtl/elixirchip_es1_spu_op_sel_lane.sv
// elixirchip_es1_spu_op_sel_lane: one output lane, select/clear stage followed by a delay chain
module elixirchip_es1_spu_op_sel_lane
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int N = 4,
  parameter int SEL_BITS = 2,
  parameter int DATA_BITS = 8,
  parameter logic [DATA_BITS-1:0] CLEAR_DATA = '1,
  parameter bit USE_CLEAR = 1,
  parameter bit USE_VALID = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cke,
  input  logic [SEL_BITS-1:0]           sel,
  input  logic [N-1:0][DATA_BITS-1:0]   data,
  input  logic                          clear,
  input  logic                          valid,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_valid,
  output logic                          m_sel_err
);
  lane_t pipe [LATENCY];
  lane_t nxt;
  logic clr, vld, in_range;
  assign clr = USE_CLEAR && clear;
  assign vld = !USE_VALID || valid;
  assign in_range = int'(sel) < N;
  // Stage 1 holds its data on idle or bad-selector cycles; only valid/err are recomputed.
  always_comb begin
    nxt.data = clr ? DATA_MAX'(CLEAR_DATA) : (vld && in_range) ? DATA_MAX'(data[sel]) : pipe[0].data;
    nxt.valid = clr || (vld && in_range);
    nxt.err = !clr && vld && !in_range;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      for (int k = 0; k < LATENCY; k++) pipe[k] <= '0;
    else if (cke) begin
      pipe[0] <= nxt;
      for (int k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
    end
  assign m_data = pipe[LATENCY-1].data[DATA_BITS-1:0];
  assign m_valid = pipe[LATENCY-1].valid;
  assign m_sel_err = pipe[LATENCY-1].err;
endmodule

// File: rtl/elixirchip_es1_spu_op_sel_xbar.sv
// elixirchip_es1_spu_op_sel_xbar: M independent pipelined N:1 operand selectors over shared data inputs
module elixirchip_es1_spu_op_sel_xbar
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int N = 4,
  parameter int M = 2,
  parameter int SEL_BITS = $clog2(N),
  parameter int DATA_BITS = 8,
  parameter logic [DATA_BITS-1:0] CLEAR_DATA = '1,
  parameter bit USE_CLEAR = 1,
  parameter bit USE_VALID = 1,
  parameter string DEVICE = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG = "false"
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cke,
  input  logic [M-1:0][SEL_BITS-1:0]    s_sel,
  input  logic [N-1:0][DATA_BITS-1:0]   s_data,
  input  logic [M-1:0]                  s_clear,
  input  logic [M-1:0]                  s_valid,
  output logic [M-1:0][DATA_BITS-1:0]   m_data,
  output logic [M-1:0]                  m_valid,
  output logic [M-1:0]                  m_sel_err
);
  if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("LATENCY must be in 1..%0d", LATENCY_MAX);
  end
  if (DATA_BITS < 1 || DATA_BITS > DATA_MAX) begin : g_bad_width
    $error("DATA_BITS must be in 1..%0d", DATA_MAX);
  end
  if (DEVICE == "" || (SIMULATION != "true" && SIMULATION != "false") || (DEBUG != "true" && DEBUG != "false")) begin : g_bad_mode
    $error("DEVICE must be set and SIMULATION/DEBUG must be \"true\" or \"false\"");
  end
  for (genvar i = 0; i < M; i++) begin : g_lane
    elixirchip_es1_spu_op_sel_lane #(
      .LATENCY(LATENCY), .N(N), .SEL_BITS(SEL_BITS), .DATA_BITS(DATA_BITS),
      .CLEAR_DATA(CLEAR_DATA), .USE_CLEAR(USE_CLEAR), .USE_VALID(USE_VALID)
    ) u_lane (
      .clk(clk),
      .reset_n(reset_n),
      .cke(cke),
      .sel(s_sel[i]),
      .data(s_data),
      .clear(s_clear[i]),
      .valid(s_valid[i]),
      .m_data(m_data[i]),
      .m_valid(m_valid[i]),
      .m_sel_err(m_sel_err[i])
    );
  end
endmodule
